// File: rtl/seq_det_ctrl_pkg.sv
// Shared definitions for the serial pattern detector controller.
package seq_det_ctrl_pkg;
   localparam int PAT_W_DEF = 4;
   localparam int CNT_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;
endpackage

// File: rtl/seq_det_core.sv
// Bit history, fill counter and Mealy comparator for the pattern detector.
module seq_det_core
   import seq_det_ctrl_pkg::*;
#(
   parameter int PAT_W = PAT_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             din,
   input  logic             din_valid,
   input  logic             enable,
   input  logic             clear,
   input  logic [PAT_W-1:0] pattern,
   output logic             match
);
   localparam int FILL_W = $clog2(PAT_W);
   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

   logic [PAT_W-2:0]  hist_q, hist_d;
   logic [FILL_W-1:0] fill_q, fill_d;

   always_comb begin
      hist_d = hist_q;
      fill_d = fill_q;
      if (clear) begin
         hist_d = '0;
         fill_d = '0;
      end else if (enable && din_valid) begin
         // newest bit enters at the LSB, oldest falls off the top
         hist_d = (PAT_W-1)'({hist_q, din});
         if (fill_q != FILL_MAX)
            fill_d = fill_q + FILL_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hist_q <= '0;
         fill_q <= '0;
      end else begin
         hist_q <= hist_d;
         fill_q <= fill_d;
      end
   end

   assign match = enable && din_valid && (fill_q == FILL_MAX) && ({hist_q, din} == pattern);
endmodule

// File: rtl/seq_det_ctrl.sv
// Run controller: config registers, FSM and match counter around seq_det_core.
//  state | meaning
//  IDLE  | waiting for start, config writable
//  RUN   | detecting and counting matches
//  DONE  | threshold reached, count held, config writable
module seq_det_ctrl
   import seq_det_ctrl_pkg::*;
#(
   parameter int PAT_W = PAT_W_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cfg_we,
   input  logic [PAT_W-1:0] cfg_pattern,
   input  logic             cfg_overlap,
   input  logic [CNT_W-1:0] cfg_threshold,
   input  logic             start,
   input  logic             stop,
   input  logic             din,
   input  logic             din_valid,
   output logic             match,
   output logic [CNT_W-1:0] match_count,
   output logic             busy,
   output logic             done
);
   state_t           state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [PAT_W-1:0] pat_q, pat_d;
   logic [CNT_W-1:0] thr_q, thr_d;
   logic             ovl_q, ovl_d;

   logic             cfg_open;
   logic             start_acc;
   logic             core_en;
   logic             core_clr;
   logic [CNT_W-1:0] cnt_inc;
   logic             thr_hit;

   assign cfg_open  = (state_q != RUN);
   assign start_acc = cfg_open && start && !stop;
   assign core_en   = (state_q == RUN) && !stop;
   // non-overlap mode needs a full fresh pattern after each hit
   assign core_clr  = start_acc || (match && !ovl_q);
   assign cnt_inc   = count_q + CNT_W'(1);
   assign thr_hit   = (thr_q != '0) && (cnt_inc == thr_q);

   seq_det_core #(.PAT_W(PAT_W)) u_core (
      .clk       (clk),
      .reset     (reset),
      .din       (din),
      .din_valid (din_valid),
      .enable    (core_en),
      .clear     (core_clr),
      .pattern   (pat_q),
      .match     (match)
   );

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      pat_d   = pat_q;
      thr_d   = thr_q;
      ovl_d   = ovl_q;
      if (cfg_open && cfg_we) begin
         pat_d = cfg_pattern;
         thr_d = cfg_threshold;
         ovl_d = cfg_overlap;
      end
      case (state_q)
         IDLE, DONE: begin
            if (stop) begin
               state_d = IDLE;
            end else if (start) begin
               state_d = RUN;
               count_d = '0;
            end
         end
         RUN: begin
            if (stop) begin
               state_d = IDLE;
            end else if (match) begin
               if (!(&count_q))
                  count_d = cnt_inc;
               if (thr_hit)
                  state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d == RUN);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         count_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pat_q   <= '0;
         thr_q   <= '0;
         ovl_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pat_q   <= pat_d;
         thr_q   <= thr_d;
         ovl_q   <= ovl_d;
      end
   end

   assign match_count = count_q;
   assign busy        = busy_q;
   assign done        = done_q;
endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed self-checking bench for seq_det_ctrl (PAT_W=4, CNT_W=8).
module tb_seq_det_ctrl;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       cfg_we = 1'b0;
   logic [3:0] cfg_pattern = '0;
   logic       cfg_overlap = 1'b0;
   logic [7:0] cfg_threshold = '0;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic       din = 1'b0;
   logic       din_valid = 1'b0;
   logic       match;
   logic [7:0] match_count;
   logic       busy;
   logic       done;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   seq_det_ctrl #(.PAT_W(4), .CNT_W(8)) dut (
      .clk           (clk),
      .reset         (reset),
      .cfg_we        (cfg_we),
      .cfg_pattern   (cfg_pattern),
      .cfg_overlap   (cfg_overlap),
      .cfg_threshold (cfg_threshold),
      .start         (start),
      .stop          (stop),
      .din           (din),
      .din_valid     (din_valid),
      .match         (match),
      .match_count   (match_count),
      .busy          (busy),
      .done          (done)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic status(input string tag, input logic [7:0] ecnt, input logic ebusy, input logic edone);
      chk({tag, "_count"}, 32'(match_count), 32'(ecnt));
      chk({tag, "_busy"}, 32'(busy), 32'(ebusy));
      chk({tag, "_done"}, 32'(done), 32'(edone));
   endtask

   // drive one bit at negedge, check Mealy output, advance past the posedge
   task automatic bit_in(input string tag, input logic b, input logic v, input logic em);
      @(negedge clk);
      din = b;
      din_valid = v;
      #1;
      chk(tag, 32'(match), 32'(em));
      @(posedge clk);
      #1;
   endtask

   task automatic bits4(input string tag, input logic [3:0] b, input logic [3:0] em);
      for (int i = 3; i >= 0; i--)
         bit_in($sformatf("%s_b%0d", tag, 4 - i), b[i], 1'b1, em[i]);
   endtask

   task automatic do_cfg(input logic [3:0] p, input logic o, input logic [7:0] t);
      @(negedge clk);
      din_valid = 1'b0;
      cfg_we = 1'b1;
      cfg_pattern = p;
      cfg_overlap = o;
      cfg_threshold = t;
      @(posedge clk);
      #1;
      cfg_we = 1'b0;
   endtask

   task automatic do_start();
      @(negedge clk);
      din_valid = 1'b0;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic do_stop();
      @(negedge clk);
      din_valid = 1'b0;
      stop = 1'b1;
      @(posedge clk);
      #1;
      stop = 1'b0;
   endtask

   initial begin
      #2;
      chk("rst_match", 32'(match), 32'd0);
      status("rst", 8'd0, 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b0;

      // 1: overlap, stream 1011011 -> hits on bits 4 and 7
      do_cfg(4'b1011, 1'b1, 8'd0);
      do_start();
      status("t1_start", 8'd0, 1'b1, 1'b0);
      bits4("t1a", 4'b1011, 4'b0001);
      chk("t1_cnt_after4", 32'(match_count), 32'd1);
      bit_in("t1_b5", 1'b0, 1'b1, 1'b0);
      bit_in("t1_b6", 1'b1, 1'b1, 1'b0);
      bit_in("t1_b7", 1'b1, 1'b1, 1'b1);
      status("t1_end", 8'd2, 1'b1, 1'b0);

      // 2: non-overlap, same stream -> hit on bit 4 only
      do_stop();
      status("t2_stop", 8'd2, 1'b0, 1'b0);
      do_cfg(4'b1011, 1'b0, 8'd0);
      do_start();
      bits4("t2a", 4'b1011, 4'b0001);
      bit_in("t2_b5", 1'b0, 1'b1, 1'b0);
      bit_in("t2_b6", 1'b1, 1'b1, 1'b0);
      bit_in("t2_b7", 1'b1, 1'b1, 1'b0);
      status("t2_end", 8'd1, 1'b1, 1'b0);

      // 3: threshold 2, stream 1011011011
      do_stop();
      do_cfg(4'b1011, 1'b1, 8'd2);
      do_start();
      bits4("t3a", 4'b1011, 4'b0001);
      bit_in("t3_b5", 1'b0, 1'b1, 1'b0);
      bit_in("t3_b6", 1'b1, 1'b1, 1'b0);
      bit_in("t3_b7", 1'b1, 1'b1, 1'b1);
      status("t3_done", 8'd2, 1'b0, 1'b1);
      bit_in("t3_b8", 1'b0, 1'b1, 1'b0);
      bit_in("t3_b9", 1'b1, 1'b1, 1'b0);
      bit_in("t3_b10", 1'b1, 1'b1, 1'b0);
      status("t3_hold", 8'd2, 1'b0, 1'b1);
      do_start();
      status("t3_restart", 8'd0, 1'b1, 1'b0);

      // 4: gaps of 3 invalid cycles carrying inverted garbage
      do_stop();
      do_cfg(4'b1011, 1'b1, 8'd0);
      do_start();
      begin
         logic [3:0] p;
         p = 4'b1011;
         for (int i = 3; i >= 0; i--) begin
            bit_in($sformatf("t4_v%0d", 4 - i), p[i], 1'b1, (i == 0));
            for (int g = 0; g < 3; g++)
               bit_in($sformatf("t4_g%0d_%0d", 4 - i, g), ~p[i], 1'b0, 1'b0);
         end
      end
      status("t4_end", 8'd1, 1'b1, 1'b0);

      // 5: stop on the final bit suppresses the hit
      do_stop();
      do_start();
      bit_in("t5_b1", 1'b1, 1'b1, 1'b0);
      bit_in("t5_b2", 1'b0, 1'b1, 1'b0);
      bit_in("t5_b3", 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      din = 1'b1;
      din_valid = 1'b1;
      stop = 1'b1;
      #1;
      chk("t5_stop_match", 32'(match), 32'd0);
      @(posedge clk);
      #1;
      stop = 1'b0;
      status("t5_stopped", 8'd0, 1'b0, 1'b0);
      // cfg writes during RUN must be ignored
      do_start();
      do_cfg(4'b0000, 1'b0, 8'd1);
      bits4("t5z", 4'b0000, 4'b0000);
      bits4("t5p", 4'b1011, 4'b0001);
      status("t5_end", 8'd1, 1'b1, 1'b0);

      // 6: async reset mid-run clears everything including config
      do_stop();
      do_start();
      bits4("t6a", 4'b1011, 4'b0001);
      bit_in("t6_b5", 1'b0, 1'b1, 1'b0);
      bit_in("t6_b6", 1'b1, 1'b1, 1'b0);
      bit_in("t6_b7", 1'b1, 1'b1, 1'b1);
      status("t6_pre", 8'd2, 1'b1, 1'b0);
      @(negedge clk);
      din = 1'b1;
      din_valid = 1'b1;
      #2;
      reset = 1'b1;
      #1;
      chk("t6_rst_match", 32'(match), 32'd0);
      status("t6_rst", 8'd0, 1'b0, 1'b0);
      #1;
      reset = 1'b0;
      do_start();
      bits4("t6z", 4'b0000, 4'b0001);
      status("t6_end", 8'd1, 1'b1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
